// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder
//   PS/2 keyboard front end. Synchronises and deglitches raw ps2_clk/ps2_data,
//   deserialises 11-bit frames, folds E0 (extended) / F0 (break) prefixes into
//   the following code byte, tracks which of NUM_KEYS table keys are held and
//   reports the most recently pressed held key as a direction index.
//
//   Optional feature: define PS2_PARITY_CHECK_EN to drop frames with bad odd
//   parity (frame_err pulse, prefix flags kept). Without it the parity bit is
//   consumed and ignored.
//
// Ports
//   clk, rst         system clock, synchronous active-high reset
//   ps2_clk/ps2_data raw asynchronous PS/2 lines
//   key_valid        1-cycle strobe, a complete scan code was decoded
//   key_code/ext/brk code byte and prefix flags, held until next key_valid
//   key_held         bit i set while table key i is pressed
//   dir_idx          index of the most recently pressed held key
//   dir_active       any table key held
//   frame_err        1-cycle strobe, a frame was dropped (stop/timeout/parity)
module ps2_key_decoder #(
   parameter int                    NUM_KEYS       = 4,
   parameter logic [NUM_KEYS*9-1:0] KEY_CODES      = {9'h174, 9'h16B, 9'h172, 9'h175},
   parameter int                    FILTER_LEN     = 8,
   parameter int                    TIMEOUT_CYCLES = 50000,
   parameter int                    IDX_W          = $clog2(NUM_KEYS)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                ps2_clk,
   input  logic                ps2_data,
   output logic                key_valid,
   output logic [7:0]          key_code,
   output logic                key_ext,
   output logic                key_break,
   output logic [NUM_KEYS-1:0] key_held,
   output logic [IDX_W-1:0]    dir_idx,
   output logic                dir_active,
   output logic                frame_err
);

   localparam int FCW = $clog2(FILTER_LEN + 1);
   localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

   logic [1:0]          clk_s_q, clk_s_d, dat_s_q, dat_s_d;
   logic                filt_q, filt_d;
   logic [FCW-1:0]      fcnt_q, fcnt_d;
   state_t              st_q, st_d;
   logic [2:0]          bcnt_q, bcnt_d;
   logic [7:0]          shift_q, shift_d;
   logic [TCW-1:0]      tmo_q, tmo_d;
   logic                byte_rdy_q, byte_rdy_d;
   logic [7:0]          byte_q, byte_d;
   logic                ext_q, ext_d, brk_q, brk_d;
   logic                key_valid_q, key_valid_d;
   logic [7:0]          key_code_q, key_code_d;
   logic                key_ext_q, key_ext_d, key_break_q, key_break_d;
   logic [NUM_KEYS-1:0] held_q, held_d;
   logic [IDX_W-1:0]    dir_q, dir_d;
   logic                act_q, act_d;
   logic                frame_err_q, frame_err_d;
`ifdef PS2_PARITY_CHECK_EN
   logic                par_ok_q, par_ok_d;
`endif

   logic                clk_in, dat_in, strobe, stop_ok, hit;
   logic [IDX_W-1:0]    hit_idx;
   logic [NUM_KEYS-1:0] held_nxt;

   always_comb begin
      clk_s_d     = {clk_s_q[0], ps2_clk};
      dat_s_d     = {dat_s_q[0], ps2_data};
      clk_in      = clk_s_q[1];
      dat_in      = dat_s_q[1];
      filt_d      = filt_q;
      fcnt_d      = fcnt_q;
      st_d        = st_q;
      bcnt_d      = bcnt_q;
      shift_d     = shift_q;
      tmo_d       = tmo_q;
      byte_rdy_d  = 1'b0;
      byte_d      = byte_q;
      ext_d       = ext_q;
      brk_d       = brk_q;
      key_valid_d = 1'b0;
      key_code_d  = key_code_q;
      key_ext_d   = key_ext_q;
      key_break_d = key_break_q;
      held_d      = held_q;
      dir_d       = dir_q;
      act_d       = act_q;
      frame_err_d = 1'b0;
      strobe      = 1'b0;
      stop_ok     = 1'b0;
      hit         = 1'b0;
      hit_idx     = '0;
      held_nxt    = held_q;
`ifdef PS2_PARITY_CHECK_EN
      par_ok_d    = par_ok_q;
`endif

      // Filtered clock follows the synced line only after FILTER_LEN
      // consecutive differing samples; a 1->0 move of it is the bit strobe.
      if (clk_in != filt_q) begin
         if (fcnt_q == FCW'(FILTER_LEN - 1)) begin
            filt_d = clk_in;
            fcnt_d = '0;
            strobe = filt_q;
         end else begin
            fcnt_d = fcnt_q + 1'b1;
         end
      end else begin
         fcnt_d = '0;
      end

      case (st_q)
         S_IDLE: begin
            tmo_d = '0;
            if (strobe && !dat_in) begin
               st_d   = S_DATA;
               bcnt_d = '0;
            end
         end
         S_DATA: if (strobe) begin
            shift_d = {dat_in, shift_q[7:1]};
            bcnt_d  = bcnt_q + 1'b1;
            if (bcnt_q == 3'd7) st_d = S_PARITY;
         end
         S_PARITY: if (strobe) begin
`ifdef PS2_PARITY_CHECK_EN
            par_ok_d = ^{shift_q, dat_in};
`endif
            st_d = S_STOP;
         end
         S_STOP: if (strobe) begin
            st_d = S_IDLE;
`ifdef PS2_PARITY_CHECK_EN
            stop_ok = dat_in && par_ok_q;
`else
            stop_ok = dat_in;
`endif
            if (stop_ok) begin
               byte_rdy_d = 1'b1;
               byte_d     = shift_q;
            end else begin
               frame_err_d = 1'b1;
            end
         end
         default: st_d = S_IDLE;
      endcase

      // Mid-frame watchdog: a stalled keyboard must not wedge the receiver.
      if (st_q != S_IDLE) begin
         if (strobe) begin
            tmo_d = '0;
         end else if (tmo_q == TCW'(TIMEOUT_CYCLES - 1)) begin
            st_d        = S_IDLE;
            frame_err_d = 1'b1;
            tmo_d       = '0;
         end else begin
            tmo_d = tmo_q + 1'b1;
         end
      end

      // Byte handling one cycle after the stop strobe.
      if (byte_rdy_q) begin
         if (byte_q == 8'hE0) begin
            ext_d = 1'b1;
         end else if (byte_q == 8'hF0) begin
            brk_d = 1'b1;
         end else begin
            key_valid_d = 1'b1;
            key_code_d  = byte_q;
            key_ext_d   = ext_q;
            key_break_d = brk_q;
            ext_d       = 1'b0;
            brk_d       = 1'b0;
            for (int i = 0; i < NUM_KEYS; i++) begin
               if (!hit && ({ext_q, byte_q} == KEY_CODES[i*9 +: 9])) begin
                  hit     = 1'b1;
                  hit_idx = IDX_W'(i);
               end
            end
            if (hit) begin
               held_nxt[hit_idx] = !brk_q;
               held_d            = held_nxt;
               act_d             = |held_nxt;
               if (!brk_q) begin
                  dir_d = hit_idx;
               end else if (dir_q == hit_idx) begin
                  // Fall back to the lowest-index key still held; descending
                  // scan so the last assignment wins with the lowest index.
                  for (int i = NUM_KEYS - 1; i >= 0; i--) begin
                     if (held_nxt[i]) dir_d = IDX_W'(i);
                  end
               end
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         // Lines idle high, so the sync chain and filter start high to avoid
         // a spurious edge out of reset.
         clk_s_q     <= 2'b11;
         dat_s_q     <= 2'b11;
         filt_q      <= 1'b1;
         fcnt_q      <= '0;
         st_q        <= S_IDLE;
         bcnt_q      <= '0;
         shift_q     <= '0;
         tmo_q       <= '0;
         byte_rdy_q  <= 1'b0;
         byte_q      <= '0;
         ext_q       <= 1'b0;
         brk_q       <= 1'b0;
         key_valid_q <= 1'b0;
         key_code_q  <= '0;
         key_ext_q   <= 1'b0;
         key_break_q <= 1'b0;
         held_q      <= '0;
         dir_q       <= '0;
         act_q       <= 1'b0;
         frame_err_q <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
         par_ok_q    <= 1'b0;
`endif
      end else begin
         clk_s_q     <= clk_s_d;
         dat_s_q     <= dat_s_d;
         filt_q      <= filt_d;
         fcnt_q      <= fcnt_d;
         st_q        <= st_d;
         bcnt_q      <= bcnt_d;
         shift_q     <= shift_d;
         tmo_q       <= tmo_d;
         byte_rdy_q  <= byte_rdy_d;
         byte_q      <= byte_d;
         ext_q       <= ext_d;
         brk_q       <= brk_d;
         key_valid_q <= key_valid_d;
         key_code_q  <= key_code_d;
         key_ext_q   <= key_ext_d;
         key_break_q <= key_break_d;
         held_q      <= held_d;
         dir_q       <= dir_d;
         act_q       <= act_d;
         frame_err_q <= frame_err_d;
`ifdef PS2_PARITY_CHECK_EN
         par_ok_q    <= par_ok_d;
`endif
      end
   end

   assign key_valid  = key_valid_q;
   assign key_code   = key_code_q;
   assign key_ext    = key_ext_q;
   assign key_break  = key_break_q;
   assign key_held   = held_q;
   assign dir_idx    = dir_q;
   assign dir_active = act_q;
   assign frame_err  = frame_err_q;

endmodule
